// File: rtl/demux_route_pkg.sv
// Shared definitions for the demux_route_ctrl slice: FSM state encoding,
// routing mode constants and the default data width.
package demux_route_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  localparam logic MODE_TAG = 1'b0;
  localparam logic MODE_ALT = 1'b1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/demux_route_ctrl_if.sv
// Handshake/bus bundle for demux_route_ctrl: one valid/ready input stream
// and two valid/ready sink ports. master = producer/sink side, slave = controller.
interface demux_route_ctrl_if
  import demux_route_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dest;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  modport master (
    output in_valid, in_data, in_dest, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

  modport slave (
    input  in_valid, in_data, in_dest, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data
  );

endinterface

// File: rtl/_DEMUX_1to2_16b.sv
// Existing 1-to-2 demultiplexer of the K_ALU result path. The unselected
// output is driven to zero.
module _DEMUX_1to2_16b #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1
);

  // Steer din to the selected output only.
  always_comb begin
    dout0 = '0;
    dout1 = '0;
    if (sel) dout1 = din;
    else     dout0 = din;
  end

endmodule

// File: rtl/demux_route_slot.sv
// Single-port holding register with valid/ready. A load in the same cycle
// as a consume keeps the slot full with the new word.
module demux_route_slot #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Load has priority over consume; data is held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_route_ctrl.sv
// Route sequencer for the K_ALU result demux. Steers each accepted word to
// sink port 0 or 1 by tag or by strict alternation; a mode change drains both
// ports first. Optional per-port handshake counters: DEMUX_ROUTE_CNT_EN.
module demux_route_ctrl
  import demux_route_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_req,
  output logic               mode_cur,
  output logic               sel,
  output logic               draining,
  demux_route_ctrl_if.slave  bus
`ifdef DEMUX_ROUTE_CNT_EN
  ,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1
`endif
);

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("demux_route_ctrl: CNT_W must be at least 1");
  end

  state_e           state;
  logic             alt_ptr;
  logic             tgt;
  logic             tgt_busy;
  logic             accept;
  logic             load0;
  logic             load1;
  logic [WIDTH-1:0] dmx0;
  logic [WIDTH-1:0] dmx1;

  // Target selection and input acceptance.
  always_comb begin
    tgt         = (mode_cur == MODE_ALT) ? alt_ptr : bus.in_dest;
    tgt_busy    = tgt ? (bus.out1_valid && !bus.out1_ready)
                      : (bus.out0_valid && !bus.out0_ready);
    bus.in_ready = (state == ST_RUN) && (mode_req == mode_cur) && !tgt_busy;
    accept      = bus.in_valid && bus.in_ready;
    load0       = accept && !tgt;
    load1       = accept && tgt;
    sel         = tgt;
  end

  // Mode FSM: RUN accepts words, DRAIN waits for both ports to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      mode_cur <= MODE_TAG;
      alt_ptr  <= 1'b0;
      draining <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mode_req != mode_cur) begin
            state    <= ST_DRAIN;
            draining <= 1'b1;
          end else if (accept && (mode_cur == MODE_ALT)) begin
            alt_ptr <= ~alt_ptr;
          end
        end
        ST_DRAIN: begin
          if (!bus.out0_valid && !bus.out1_valid) begin
            state    <= ST_RUN;
            draining <= 1'b0;
            mode_cur <= mode_req;
            alt_ptr  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_RUN;
          draining <= 1'b0;
        end
      endcase
    end
  end

  _DEMUX_1to2_16b #(.WIDTH(WIDTH)) u_demux (
    .sel   (tgt),
    .din   (bus.in_data),
    .dout0 (dmx0),
    .dout1 (dmx1)
  );

  demux_route_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (dmx0),
    .ready     (bus.out0_ready),
    .valid     (bus.out0_valid),
    .data      (bus.out0_data)
  );

  demux_route_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (dmx1),
    .ready     (bus.out1_ready),
    .valid     (bus.out1_valid),
    .data      (bus.out1_data)
  );

`ifdef DEMUX_ROUTE_CNT_EN
  // Saturating per-port handshake counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (bus.out0_valid && bus.out0_ready && (cnt0 != '1)) cnt0 <= cnt0 + 1'b1;
      if (bus.out1_valid && bus.out1_ready && (cnt1 != '1)) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Self-checking bench for demux_route_ctrl: directed steps followed by a
// randomized phase, all checked every cycle against a behavioural model
// plus per-port in-order scoreboards.
module tb_demux_route_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  logic mode_req;
  logic mode_cur;
  logic sel;
  logic draining;
`ifdef DEMUX_ROUTE_CNT_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  demux_route_ctrl_if #(.WIDTH(16)) bus ();

  demux_route_ctrl #(.WIDTH(16), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_req (mode_req),
    .mode_cur (mode_cur),
    .sel      (sel),
    .draining (draining),
    .bus      (bus)
`ifdef DEMUX_ROUTE_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Behavioural model
  bit          m_run = 1'b1;
  logic        m_mode = 1'b0;
  logic        m_alt = 1'b0;
  logic        m_v [2] = '{1'b0, 1'b0};
  logic [15:0] m_d [2] = '{16'h0, 16'h0};
  int unsigned m_cnt [2] = '{0, 0};
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return at posedge+1.
  task automatic tick();
    logic        t, rdy, acc, rst_s, mreq_s;
    logic        r [2];
    logic        hs [2];
    logic [15:0] din, e;
    @(negedge clk);
    r[0]   = bus.out0_ready;
    r[1]   = bus.out1_ready;
    rst_s  = rst;
    mreq_s = mode_req;
    din    = bus.in_data;
    t      = m_mode ? m_alt : bus.in_dest;
    rdy    = m_run && (mode_req == m_mode) && (!m_v[t] || r[t]);
    acc    = bus.in_valid && rdy;
    hs[0]  = m_v[0] && r[0];
    hs[1]  = m_v[1] && r[1];

    chk("in_ready",   {31'b0, bus.in_ready},   {31'b0, rdy});
    chk("sel",        {31'b0, sel},            {31'b0, t});
    chk("mode_cur",   {31'b0, mode_cur},       {31'b0, m_mode});
    chk("draining",   {31'b0, draining},       {31'b0, !m_run});
    chk("out0_valid", {31'b0, bus.out0_valid}, {31'b0, m_v[0]});
    chk("out1_valid", {31'b0, bus.out1_valid}, {31'b0, m_v[1]});
    chk("out0_data",  {16'b0, bus.out0_data},  {16'b0, m_d[0]});
    chk("out1_data",  {16'b0, bus.out1_data},  {16'b0, m_d[1]});
`ifdef DEMUX_ROUTE_CNT_EN
    chk("cnt0", {{(32-CNT_W){1'b0}}, cnt0}, m_cnt[0]);
    chk("cnt1", {{(32-CNT_W){1'b0}}, cnt1}, m_cnt[1]);
`endif
    if (hs[0]) begin
      e = 'x;
      if (q0.size() > 0) e = q0.pop_front();
      chk("order0", {16'b0, bus.out0_data}, {16'b0, e});
    end
    if (hs[1]) begin
      e = 'x;
      if (q1.size() > 0) e = q1.pop_front();
      chk("order1", {16'b0, bus.out1_data}, {16'b0, e});
    end

    @(posedge clk);
    if (rst_s) begin
      m_run = 1'b1; m_mode = 1'b0; m_alt = 1'b0;
      m_v = '{1'b0, 1'b0}; m_d = '{16'h0, 16'h0}; m_cnt = '{0, 0};
      q0.delete(); q1.delete();
    end else begin
      if (m_run) begin
        if (mreq_s != m_mode) m_run = 1'b0;
        else if (acc && m_mode) m_alt = ~m_alt;
      end else if (!m_v[0] && !m_v[1]) begin
        m_run = 1'b1; m_mode = mreq_s; m_alt = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (hs[p] && m_cnt[p] < CNT_MAX) m_cnt[p]++;
        if (acc && (int'(t) == p)) begin
          m_v[p] = 1'b1;
          m_d[p] = din;
          if (p == 0) q0.push_back(din); else q1.push_back(din);
        end else if (hs[p]) begin
          m_v[p] = 1'b0;
        end
      end
    end
    #1;
  endtask

  // Tick until DRAIN ends, bounded.
  task automatic wait_run();
    for (int i = 0; i < 20; i++) begin
      if (!draining) break;
      tick();
    end
    chk("drain_timeout", {31'b0, draining}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; mode_req = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 16'h0; bus.in_dest = 1'b0;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    chk("rst_mode", {31'b0, mode_cur}, 32'd0);
    chk("rst_v0", {31'b0, bus.out0_valid}, 32'd0);
    chk("rst_d1", {16'b0, bus.out1_data}, 32'd0);

    // Tag mode, both sinks ready
    bus.in_valid = 1'b1; bus.in_data = 16'h1234; bus.in_dest = 1'b1;
    tick();
    chk("tag_out1_valid", {31'b0, bus.out1_valid}, 32'd1);
    chk("tag_out1_data", {16'b0, bus.out1_data}, 32'h1234);
    bus.in_data = 16'hABCD; bus.in_dest = 1'b0;
    tick();
    chk("tag_out0_data", {16'b0, bus.out0_data}, 32'hABCD);
    chk("tag_out1_consumed", {31'b0, bus.out1_valid}, 32'd0);
    bus.in_valid = 1'b0;
    tick();

    // Switch to alternate mode and stream four words
    mode_req = 1'b1;
    tick();
    chk("alt_drain_ready", {31'b0, bus.in_ready}, 32'd0);
    wait_run();
    chk("alt_mode", {31'b0, mode_cur}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'(i);
      tick();
      if (i % 2 == 1) chk("alt_port0", {16'b0, bus.out0_data}, i);
      else            chk("alt_port1", {16'b0, bus.out1_data}, i);
    end
    // Stall port 1 while it holds word 4
    bus.out1_ready = 1'b0; bus.in_data = 16'h0005;
    tick();
    bus.in_data = 16'h0006;
    repeat (3) tick();
    chk("alt_stall_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("alt_stall_hold", {16'b0, bus.out1_data}, 32'h0004);
    chk("alt_stall_sel", {31'b0, sel}, 32'd1);
    bus.out1_ready = 1'b1;
    tick();
    chk("alt_release", {16'b0, bus.out1_data}, 32'h0006);
    bus.in_valid = 1'b0;
    tick();

    // Back to tag mode; port 1 stalled does not block port 0
    mode_req = 1'b0;
    tick();
    wait_run();
    bus.out1_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_dest = 1'b1; bus.in_data = 16'h0077;
    tick();
    bus.in_dest = 1'b0; bus.in_data = 16'h00AA;
    tick();
    chk("tag_p0_aa", {16'b0, bus.out0_data}, 32'h00AA);
    bus.in_data = 16'h00BB;
    tick();
    chk("tag_p0_bb", {16'b0, bus.out0_data}, 32'h00BB);
    chk("tag_p1_hold", {16'b0, bus.out1_data}, 32'h0077);

    // Mode change with both ports full and sinks stalled
    bus.in_valid = 1'b0; bus.out0_ready = 1'b0;
    tick();
    mode_req = 1'b1;
    repeat (3) tick();
    chk("full_draining", {31'b0, draining}, 32'd1);
    chk("full_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    tick();
    chk("full_still_draining", {31'b0, draining}, 32'd1);
    tick();
    chk("full_exit_draining", {31'b0, draining}, 32'd0);
    chk("full_exit_mode", {31'b0, mode_cur}, 32'd1);
    chk("full_exit_alt_ptr", {31'b0, sel}, 32'd0);

    // Reset mid-DRAIN with port 0 holding a word
    bus.out0_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h5555;
    tick();
    bus.in_valid = 1'b0; mode_req = 1'b0;
    tick();
    chk("rd_draining", {31'b0, draining}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rd_draining_clr", {31'b0, draining}, 32'd0);
    chk("rd_v0", {31'b0, bus.out0_valid}, 32'd0);
    chk("rd_d0", {16'b0, bus.out0_data}, 32'd0);
    chk("rd_mode", {31'b0, mode_cur}, 32'd0);

    // 17 handshakes on port 0 (counters saturate at 4 bits)
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1; bus.in_dest = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'(16'h0100 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
`ifdef DEMUX_ROUTE_CNT_EN
    chk("cnt0_sat", {{(32-CNT_W){1'b0}}, cnt0}, 32'hF);
    chk("cnt1_zero", {{(32-CNT_W){1'b0}}, cnt1}, 32'h0);
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_data    = 16'($urandom);
      bus.in_dest    = 1'($urandom_range(0, 1));
      bus.out0_ready = ($urandom_range(0, 3) != 0);
      bus.out1_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) mode_req = ~mode_req;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; bus.in_valid = 1'b0;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
